md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the MIPS32 CPU execute stage. It sits beside the ALU and takes the same two register-file operand buses that feed the ALU. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a multi-cycle busy handshake, and holds the architectural HI/LO registers that MFHI/MFLO read. The controller stalls issue while `md_busy` is high.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of MULT/MULTU, in cycles (≥1).
- `DIV_CYCLES`, default 10: busy duration of DIV/DIVU, in cycles (≥1).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: reset, synchronous and active-high.
- `md_input1`  in  32: operand A (rs); dividend for divides.
- `md_input2`  in  32: operand B (rt); divisor for divides.
- `md_op`  in  3: operation select. 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO. Codes 0 and 7 are no-op.
- `md_start`  in  1: issue strobe; sampled on the rising edge.
- `md_busy`  out  1: multiply/divide operation in flight.
- `hi_out`  out  32: current HI register.
- `lo_out`  out  32: current LO register.

## Operation
- State machine has two states, IDLE and BUSY. Reset enters IDLE with HI=0, LO=0, `md_busy`=0, and the counter at 0.
- IDLE with `md_start`=1 and `md_op` in 1..4:
  - Operands and op are latched.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - Next state is BUSY.
- IDLE with `md_start`=1 and `md_op`=5: HI←`md_input1` at this edge. State stays IDLE and `md_busy` stays 0. For `md_op`=6 the same applies to LO.
- IDLE with `md_start`=1 and `md_op` 0 or 7: no effect.
- BUSY:
  - Counter decrements each cycle.
  - When the counter reaches 1, the committing edge writes HI/LO and returns to IDLE.
  - While BUSY, `md_start` is ignored for every op, including MTHI/MTLO. Operand inputs are don't-care because the latched copies are used.
- Arithmetic, always on the latched operands:
  - MULT: full 64-bit signed product; HI=[63:32], LO=[31:0].
  - MULTU: same as MULT, with unsigned operands.
  - DIV: signed, quotient truncated toward zero. LO=quotient, HI=remainder, and the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - Divisor 0 for DIV or DIVU: the op runs the full DIV_CYCLES with `md_busy`=1, then HI and LO are left unchanged. No exception is raised.
- The result may be computed combinationally from the latched operands or iteratively. It must be written to HI/LO only on the committing edge. Intermediate values must never appear on `hi_out`/`lo_out`.
- Reset during BUSY aborts the op. HI=0, LO=0, and IDLE are reached on that edge, and no commit follows.

## Timing
- Issue edge T (IDLE, `md_start`=1, `md_op` 1..4):
  - `md_busy` goes 1 after T and stays 1 for exactly L cycles, where L = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the result at edge T+L, and `md_busy` is 0 after that same edge.
- A new `md_start` is accepted at edge T+L+1 at the earliest, the first edge at which `md_busy`=0.
- MTHI/MTLO: `hi_out`/`lo_out` show the new value one cycle after the issue edge. `md_busy` is unaffected.
- `hi_out`, `lo_out` and `md_busy` are direct register outputs with no combinational input-to-output path.
- If reset and `md_start` are both high on the same edge, reset wins.

## Test plan
- Reset, then MULT with A=0xFFFFFFFD (−3), B=7 → `md_busy`=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. HI/LO must read 0 throughout the busy window.
- MULTU with A=B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001. Then DIVU 100/7 → after 10 cycles LO=14, HI=2.
- DIV with A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI with 0x12345678, then DIVU 5/0 → `md_busy` high for 10 cycles, then HI=0x12345678 and LO=0 (both unchanged).
- MULT 3×4 issued; on cycle 2 of busy, pulse `md_start` with MTLO 0xDEAD and with MULT 9×9 → both ignored, and final LO=12, HI=0.
- MULT 3×4 issued; reset asserted on cycle 3 of busy → HI=0, LO=0, `md_busy`=0 next cycle, with no later commit. A fresh MTLO 0x55 then gives LO=0x55.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: MIPS32 multiply/divide unit with architectural HI/LO registers.
//
// Executes MULT, MULTU, DIV and DIVU as multi-cycle operations that hold
// md_busy high for a fixed latency. It also executes MTHI and MTLO as
// single-edge writes that do not raise md_busy.
//
// The result is formed combinationally from operand copies latched at issue.
// It reaches HI/LO only on the committing edge, so intermediate values never
// show on the outputs.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous active-high reset (aborts any operation)
//   md_input1  in  32  operand A (rs), dividend for divides
//   md_input2  in  32  operand B (rt), divisor for divides
//   md_op      in   3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, else no-op
//   md_start   in   1  issue strobe, sampled on the rising edge
//   md_busy    out  1  multiply/divide operation in flight (registered)
//   hi_out     out 32  HI register
//   lo_out     out 32  LO register
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] md_input1,
    input  logic [31:0] md_input2,
    input  logic [2:0]  md_op,
    input  logic        md_start,
    output logic        md_busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        logic [31:0] res;
        if (v[31]) begin
            res = 32'd0 - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [2:0]       op_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic             busy_r;

    logic             issue_s;
    logic             commit_s;
    logic             mthi_s;
    logic             mtlo_s;
    logic             write_s;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_s  = state_r;
        issue_s  = 1'b0;
        commit_s = 1'b0;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (md_start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            issue_s = 1'b1;
                            state_s = ST_BUSY;
                        end
                        OP_MTHI: mthi_s = 1'b1;
                        OP_MTLO: mtlo_s = 1'b1;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    commit_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Result formation from the latched operands; a zero divisor is
    // replaced by 1 so the divider never sees 0 (its result is discarded).
    always_comb begin
        logic signed [63:0] sprod;
        logic [63:0]        uprod;
        logic [31:0]        dvs;
        logic [31:0]        a_mag;
        logic [31:0]        b_mag;
        logic [31:0]        q_mag;
        logic [31:0]        r_mag;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        sprod    = $signed(a_r) * $signed(b_r);
        uprod    = {32'd0, a_r} * {32'd0, b_r};
        if (b_r == 32'd0) begin
            dvs = 32'd1;
        end else begin
            dvs = b_r;
        end
        a_mag = mag32(a_r);
        b_mag = mag32(dvs);
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        case (op_r)
            OP_MULT: begin
                res_hi_s = sprod[63:32];
                res_lo_s = sprod[31:0];
            end
            OP_MULTU: begin
                res_hi_s = uprod[63:32];
                res_lo_s = uprod[31:0];
            end
            OP_DIV: begin
                // Quotient truncates toward zero; remainder follows dividend sign.
                if (a_r[31] ^ dvs[31]) begin
                    res_lo_s = 32'd0 - q_mag;
                end else begin
                    res_lo_s = q_mag;
                end
                if (a_r[31]) begin
                    res_hi_s = 32'd0 - r_mag;
                end else begin
                    res_hi_s = r_mag;
                end
            end
            OP_DIVU: begin
                res_lo_s = a_r / dvs;
                res_hi_s = a_r % dvs;
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
            end
        endcase
    end

    // Divide by zero runs the full latency but leaves HI/LO untouched.
    assign write_s = commit_s &&
                     !(((op_r == OP_DIV) || (op_r == OP_DIVU)) && (b_r == 32'd0));

    // Operand latch, latency counter, busy flag and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            op_r   <= 3'd0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            busy_r <= 1'b0;
        end else begin
            if (issue_s) begin
                a_r    <= md_input1;
                b_r    <= md_input2;
                op_r   <= md_op;
                busy_r <= 1'b1;
                if ((md_op == OP_MULT) || (md_op == OP_MULTU)) begin
                    cnt_r <= MULT_LOAD;
                end else begin
                    cnt_r <= DIV_LOAD;
                end
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r - CNT_ONE;
                if (commit_s) begin
                    busy_r <= 1'b0;
                end
            end
            if (write_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else if (mthi_s) begin
                hi_r <= md_input1;
            end else if (mtlo_s) begin
                lo_r <= md_input1;
            end
        end
    end

    assign md_busy = busy_r;
    assign hi_out  = hi_r;
    assign lo_out  = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking testbench for md_unit (default latencies 5 / 10).
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] md_input1;
    logic [31:0] md_input2;
    logic [2:0]  md_op;
    logic        md_start;
    logic        md_busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total;
    int bad;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_input1 (md_input1),
        .md_input2 (md_input2),
        .md_op     (md_op),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge, then scramble the operand buses.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op     = op;
        md_input1 = a;
        md_input2 = b;
        md_start  = 1'b1;
        tick();
        md_start  = 1'b0;
        md_op     = 3'd0;
        md_input1 = 32'hA5A5_A5A5;
        md_input2 = 32'h5A5A_5A5A;
    endtask

    // Expect md_busy high for n cycles with HI/LO holding their old values.
    task automatic busy_window(input string tag, input int n,
                               input logic [31:0] h, input logic [31:0] l);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, md_busy}, 32'd1);
            check({tag, "_hold_hi"}, hi_out, h);
            check({tag, "_hold_lo"}, lo_out, l);
            tick();
        end
    endtask

    task automatic expect_done(input string tag, input logic [31:0] h, input logic [31:0] l);
        check({tag, "_idle"}, {31'd0, md_busy}, 32'd0);
        check({tag, "_hi"}, hi_out, h);
        check({tag, "_lo"}, lo_out, l);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        md_start  = 1'b0;
        md_op     = 3'd0;
        md_input1 = 32'd0;
        md_input2 = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        expect_done("reset", 32'd0, 32'd0);

        // MULT -3 * 7 = -21
        issue(3'd1, 32'hFFFF_FFFD, 32'd7);
        busy_window("mult_neg", 5, 32'd0, 32'd0);
        expect_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busy_window("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        expect_done("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // DIVU 100 / 7 = 14 r 2
        issue(3'd4, 32'd100, 32'd7);
        busy_window("divu", 10, 32'hFFFF_FFFE, 32'h0000_0001);
        expect_done("divu", 32'd2, 32'd14);

        // DIV -7 / 2 = -3 r -1
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        busy_window("div_neg", 10, 32'd2, 32'd14);
        expect_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_window("div_ovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        expect_done("div_ovf", 32'd0, 32'h8000_0000);

        // MTHI / MTLO take effect one cycle after issue, no busy
        issue(3'd5, 32'h1234_5678, 32'd0);
        expect_done("mthi", 32'h1234_5678, 32'h8000_0000);
        issue(3'd6, 32'd0, 32'd0);
        expect_done("mtlo", 32'h1234_5678, 32'd0);

        // No-op code 7 changes nothing
        issue(3'd7, 32'hFFFF_0000, 32'd3);
        expect_done("nop7", 32'h1234_5678, 32'd0);

        // DIVU by zero: full latency, HI/LO unchanged
        issue(3'd4, 32'd5, 32'd0);
        busy_window("divz", 10, 32'h1234_5678, 32'd0);
        expect_done("divz", 32'h1234_5678, 32'd0);

        // Starts during BUSY are ignored
        issue(3'd1, 32'd3, 32'd4);
        tick();
        md_op = 3'd6; md_input1 = 32'h0000_DEAD; md_start = 1'b1;
        tick();
        check("ign_mtlo_lo", lo_out, 32'd0);
        md_op = 3'd1; md_input1 = 32'd9; md_input2 = 32'd9;
        tick();
        md_start = 1'b0; md_op = 3'd0;
        check("ign_busy", {31'd0, md_busy}, 32'd1);
        check("ign_hold_lo", lo_out, 32'd0);
        tick();
        check("ign_busy_last", {31'd0, md_busy}, 32'd1);
        tick();
        expect_done("ign", 32'd0, 32'd12);
        // No second op started by the ignored strobes
        tick();
        check("ign_stay_idle", {31'd0, md_busy}, 32'd0);

        // Reset during BUSY aborts; reset also wins over a coincident start
        issue(3'd5, 32'h0000_AAAA, 32'd0);
        issue(3'd1, 32'd3, 32'd4);
        tick();
        tick();
        reset = 1'b1; md_start = 1'b1; md_op = 3'd6; md_input1 = 32'h0000_0077;
        tick();
        reset = 1'b0; md_start = 1'b0; md_op = 3'd0;
        expect_done("abort", 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_done("abort_nocommit", 32'd0, 32'd0);
        end
        issue(3'd6, 32'h0000_0055, 32'd0);
        expect_done("post_mtlo", 32'd0, 32'h0000_0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
